barrett_2551_arbiter: RTL and testbench

Shares one pipelined mod-2551 Barrett reduction datapath among NUM_REQ requesters, such as NTT butterfly lanes and coefficient-load ports. A round-robin arbiter picks one requester per cycle and tags the operand with the requester index. The operand runs through a 2-stage reduction pipeline, and the reduced residue returns on a single response channel that honours backpressure.

---
 rtl/barrett_pkg.sv | 22 ++
 rtl/barrett_2551_pipe.sv | 74 +++++++
 rtl/barrett_2551_arbiter.sv | 97 +++++++++
 tb/tb_barrett_2551_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared constants and the final residue fold for the mod-2551 Barrett datapath.
package barrett_pkg;
  localparam int Q_MOD  = 2551;
  localparam int MU     = 6576;
  localparam int SHIFT  = 12;
  localparam int DIN_W  = 23;
  localparam int DOUT_W = 12;
  localparam int Q_W    = DIN_W - SHIFT;  // din >> 12
  localparam int P_W    = 25;             // q * MU, full width
  localparam int T_W    = 13;             // p >> 12
  localparam int R_W    = 14;             // partial residue, < 4*Q_MOD

  // Subtract k*Q (k in 0..3) from a partial residue known to be < 4*Q.
  function automatic logic [DOUT_W-1:0] fold_residue(input logic [R_W-1:0] r);
    logic [R_W-1:0] f;
    if (r >= R_W'(3 * Q_MOD))      f = r - R_W'(3 * Q_MOD);
    else if (r >= R_W'(2 * Q_MOD)) f = r - R_W'(2 * Q_MOD);
    else if (r >= R_W'(Q_MOD))     f = r - R_W'(Q_MOD);
    else                           f = r;
    return DOUT_W'(f);
  endfunction
endpackage

// File: rtl/barrett_2551_pipe.sv
// Two-stage Barrett reduction mod 2551 with a tag riding alongside each operand.
// The whole pipe freezes when advance is low; a bubble in S2 never blocks S1
// because an empty S2 cannot produce a stall upstream.
module barrett_2551_pipe
  import barrett_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  in_data,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [DOUT_W-1:0] out_data
);

  logic [Q_W-1:0]   q_c;
  logic [P_W-1:0]   p_c;
  logic [T_W-1:0]   t_c;
  logic [P_W-1:0]   tq_c;
  logic [P_W-1:0]   r_c;

  logic             s1_valid;
  logic [P_W-1:0]   s1_p;
  logic [DIN_W-1:0] s1_din;
  logic [ID_W-1:0]  s1_id;
  logic             s2_valid;
  logic [R_W-1:0]   s2_r;
  logic [DIN_W-1:0] s2_din;
  logic [ID_W-1:0]  s2_id;

  assign q_c  = in_data[DIN_W-1:SHIFT];
  assign p_c  = P_W'(q_c) * P_W'(MU);
  assign t_c  = T_W'(s1_p >> SHIFT);
  assign tq_c = P_W'(t_c) * P_W'(Q_MOD);
  assign r_c  = P_W'(s1_din) - tq_c;

  // Stage registers: S1 holds the quotient estimate product, S2 the partial residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_din   <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_din   <= '0;
      s2_id    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_p     <= p_c;
      s1_din   <= in_data;
      s1_id    <= in_id;
      s2_valid <= s1_valid;
      s2_r     <= R_W'(r_c);
      s2_din   <= s1_din;
      s2_id    <= s1_id;
    end
  end

  assign out_valid = s2_valid;
  assign out_id    = s2_id;
  assign out_data  = fold_residue(s2_r);

  // The carried operand lets us confirm the reduction is exact at the output.
  always @(posedge clk) begin
    if (rst_n && s2_valid)
      assert (int'(out_data) == int'(s2_din) % Q_MOD);
  end

endmodule

// File: rtl/barrett_2551_arbiter.sv
// Round-robin front end sharing one mod-2551 Barrett pipe among NUM_REQ requesters.
module barrett_2551_arbiter
  import barrett_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DOUT_W-1:0]        rsp_data,
  input  logic                     rsp_ready,
  output logic                     idle
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            stall;
  logic            accept;
  logic            xfer;
  logic [1:0]      count;
  int              idx;

  // Search req_valid from the pointer, wrapping, and take the first set bit.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = (found && !stall) ? (NUM_REQ'(1) << win) : '0;
  assign accept    = |(req_valid & req_ready);
  assign xfer      = rsp_valid & rsp_ready;
  assign idle      = (count == 2'd0);

  // Pointer moves past the winner only when the winner is actually accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (accept)
      ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
  end

  // Operations in flight: accepted but not yet handed to the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= 2'd0;
    else begin
      case ({accept, xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  barrett_2551_pipe #(
    .ID_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (~stall),
    .in_valid  (accept),
    .in_data   (req_data[int'(win)*DIN_W +: DIN_W]),
    .in_id     (win),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_data  (rsp_data)
  );

  // Structural invariants of the grant, the occupancy and the residue range.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(req_ready));
      assert (count <= 2'd2);
      if (rsp_valid) assert (rsp_data < DOUT_W'(Q_MOD));
    end
  end

endmodule

// File: tb/tb_barrett_2551_arbiter.sv
// Self-checking bench: a transaction-level model (ordered queue of pending
// residues, each needing two unstalled cycles) predicts grants and responses.
module tb_barrett_2551_arbiter;
  localparam int N  = 4;
  localparam int QM = 2551;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*23-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [11:0]   rsp_data;
  logic          rsp_ready;
  logic          idle;

  always #5 clk = ~clk;

  barrett_2551_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .idle(idle)
  );

  typedef struct {int id; int res; int age;} item_t;
  item_t sb[$];
  int ptr_m;
  int checks = 0;
  int errors = 0;
  int accepted, delivered;
  bit exp_rv, exp_stall, exp_idle;
  int exp_id, exp_data, exp_grant;
  logic [N-1:0] exp_ready;

  function automatic int model_grant(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int din_of(int i);
    return int'(req_data[23*i +: 23]);
  endfunction

  task automatic set_din(int i, logic [22:0] v);
    req_data[23*i +: 23] = v;
  endtask

  task automatic model_eval();
    exp_rv    = (sb.size() > 0) && (sb[0].age >= 2);
    exp_id    = exp_rv ? sb[0].id : 0;
    exp_data  = exp_rv ? sb[0].res : 0;
    exp_stall = exp_rv && !rsp_ready;
    exp_grant = exp_stall ? -1 : model_grant(req_valid, ptr_m);
    exp_ready = (exp_grant >= 0) ? N'(1 << exp_grant) : '0;
    exp_idle  = (sb.size() == 0);
  endtask

  task automatic model_advance();
    item_t it;
    if (exp_rv && rsp_ready) begin
      void'(sb.pop_front());
      delivered++;
    end
    if (!exp_stall)
      for (int i = 0; i < sb.size(); i++) sb[i].age++;
    if (exp_grant >= 0) begin
      it.id = exp_grant; it.res = din_of(exp_grant) % QM; it.age = 1;
      sb.push_back(it);
      ptr_m = (exp_grant + 1) % N;
      accepted++;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete(); ptr_m = 0; accepted = 0; delivered = 0;
  endtask

  task automatic drain();
    req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      settle();
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_data !== 12'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_directed();
    int vals [5] = '{0, 2551, 12345, 6507600, 8388607};
    int ress [5] = '{0, 0, 2141, 2550, 919};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      req_valid = 4'b0001; set_din(0, 23'(vals[v]));
      settle();
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL dir_grant din=%0d: got %b expected 0001", vals[v], req_ready); end
      tick();
      req_valid = '0;
      settle();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dir_early din=%0d: rsp_valid got %b expected 0", vals[v], rsp_valid); end
      tick();
      settle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 12'(ress[v])) begin
        errors++;
        $display("FAIL dir_rsp din=%0d: got v=%b id=%0d data=%0d expected v=1 id=0 data=%0d", vals[v], rsp_valid, rsp_id, rsp_data, ress[v]);
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_din(i, 23'(5102 + i));
    for (int c = 0; c < 16; c++) begin
      settle();
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rot_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_data !== 12'((c - 2) % 4)) begin
          errors++;
          $display("FAIL rot_rsp c=%0d: got v=%b id=%0d data=%0d expected id=data=%0d", c, rsp_valid, rsp_id, rsp_data, (c - 2) % 4);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    int hid, hdata;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_din(i, 23'($urandom()));
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_pre_grant: got %b expected %b", req_ready, exp_ready); end
      tick();
    end
    rsp_ready = 1'b0;
    settle();
    hid = exp_id; hdata = exp_data;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready c=%0d: got %b expected 0000", c, req_ready); end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(hid) || rsp_data !== 12'(hdata)) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d", c, rsp_valid, rsp_id, rsp_data, hid, hdata);
      end
      tick();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 6) req_valid = '0;
      settle();
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv && (rsp_id !== 2'(exp_id) || rsp_data !== 12'(exp_data)))) begin
        errors++;
        $display("FAIL bp_after c=%0d: got v=%b id=%0d data=%0d expected v=%b id=%0d data=%0d", c, rsp_valid, rsp_id, rsp_data, exp_rv, exp_id, exp_data);
      end
      tick();
    end
    settle();
    checks++; if (delivered != accepted || idle !== 1'b1) begin errors++; $display("FAIL bp_count: delivered %0d accepted %0d idle %b", delivered, accepted, idle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001; set_din(0, 23'd100);
    settle(); tick();
    req_valid = 4'b0010; set_din(1, 23'd200);
    settle();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_pre_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; sb.delete(); ptr_m = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1 || rsp_data !== 12'd0) begin errors++; $display("FAIL rmid_state: got v=%b idle=%b data=%0d expected v=0 idle=1 data=0", rsp_valid, idle, rsp_data); end
    req_valid = 4'b0110; set_din(2, 23'd300);
    settle();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_first_grant: got %b expected 0010", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_sparse();
    do_reset();
    set_din(3, 23'($urandom())); set_din(1, 23'($urandom()));
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sp_req3 c=%0d: got %b expected 1000", c, req_ready); end
      tick();
    end
    req_valid = 4'b1010;
    settle();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sp_ptr0: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sp_req1 c=%0d: got %b expected 0010", c, req_ready); end
      tick();
    end
    req_valid = 4'b0000;
    settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sp_none: got %b expected 0000", req_ready); end
    tick();
    req_valid = 4'b1011;
    settle();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sp_ptr2: got %b expected 1000", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [22:0] d;
    int g;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 15))
            0:       d = 23'd0;
            1:       d = 23'h7FFFFF;
            default: d = 23'($urandom());
          endcase
          set_din(i, d);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      checks++; if (idle !== exp_idle) begin errors++; $display("FAIL rnd_idle cyc=%0d: got %b expected %b", cyc, idle, exp_idle); end
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv && (rsp_id !== 2'(exp_id) || rsp_data !== 12'(exp_data)))) begin
        errors++;
        $display("FAIL rnd_rsp cyc=%0d: got v=%b id=%0d data=%0d expected v=%b id=%0d data=%0d", cyc, rsp_valid, rsp_id, rsp_data, exp_rv, exp_id, exp_data);
      end
      g = exp_grant;
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      settle();
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv && (rsp_id !== 2'(exp_id) || rsp_data !== 12'(exp_data)))) begin
        errors++;
        $display("FAIL rnd_drain: got v=%b id=%0d data=%0d expected v=%b id=%0d data=%0d", rsp_valid, rsp_id, rsp_data, exp_rv, exp_id, exp_data);
      end
      tick();
    end
    settle();
    checks++; if (delivered != accepted || idle !== 1'b1) begin errors++; $display("FAIL rnd_count: delivered %0d accepted %0d idle %b", delivered, accepted, idle); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
